// File: rtl/sym_pkg.sv
// Shared definitions for the 2-bit symbol link (transmitter and detector side).
package sym_pkg;

    localparam int unsigned SYM_W   = 2;
    localparam int unsigned MAX_LEN = 8;
    localparam int unsigned LEN_W   = $clog2(MAX_LEN) + 1;
    localparam int unsigned REP_W   = 4;
    localparam int unsigned GAP_W   = 4;
    localparam int unsigned IDX_W   = $clog2(MAX_LEN);
    localparam int unsigned PAT_W   = MAX_LEN * SYM_W;

    localparam logic [SYM_W-1:0] SYM_IDLE = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10,
        ST_DONE = 2'b11
    } state_e;

    // Transfer settings captured when a start is accepted
    typedef struct packed {
        logic [PAT_W-1:0] pat;
        logic [LEN_W-1:0] len;
        logic [GAP_W-1:0] gap;
    } cfg_t;

    // Lengths beyond the buffer depth are treated as a full buffer
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
        return (len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : len;
    endfunction

    // Symbol i of a pattern; symbol 0 occupies the low bits
    function automatic logic [SYM_W-1:0] sym_at(input logic [PAT_W-1:0] pat,
                                                input logic [IDX_W-1:0] idx);
        return pat[32'(idx) * SYM_W +: SYM_W];
    endfunction

endpackage

// File: rtl/sym_down_cnt.sv
// Loadable down counter that saturates at zero and flags the zero count.
module sym_down_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority over decrement
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sym_seq_tx.sv
// Symbol stream transmitter: replays a latched pattern (reps+1) times with idle gaps.
module sym_seq_tx
    import sym_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             hold_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [REP_W-1:0] reps_i,
    input  logic [GAP_W-1:0] gap_i,
    output logic [SYM_W-1:0] num_o,
    output logic             num_vld_o,
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q;
    state_e           state_d;
    cfg_t             cfg_q;
    logic [IDX_W-1:0] idx_q;

    logic accept;
    logic last_sym;
    logic pass_end;
    logic rep_zero;
    logic gap_zero;

    assign accept   = (state_q == ST_IDLE) && start_i && !abort_i;
    assign last_sym = (LEN_W'(idx_q) == (cfg_q.len - LEN_W'(1)));
    assign pass_end = (state_q == ST_SEND) && !hold_i && !abort_i && last_sym;

    // Remaining extra passes; reaching zero means the current pass is the final one
    sym_down_cnt #(.W(REP_W)) u_rep_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (reps_i),
        .en_i       (pass_end && !rep_zero),
        .zero_o     (rep_zero)
    );

    // Gap cycles still to go after the current one; loaded with gap-1 so zero marks the last
    sym_down_cnt #(.W(GAP_W)) u_gap_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (pass_end && !rep_zero && (cfg_q.gap != '0)),
        .load_val_i (cfg_q.gap - GAP_W'(1)),
        .en_i       ((state_q == ST_GAP) && !hold_i && !abort_i),
        .zero_o     (gap_zero)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; abort overrides every other transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = (len_i == '0) ? ST_DONE : ST_SEND;
                end
            end
            ST_SEND: begin
                if (!hold_i && last_sym) begin
                    if (rep_zero) begin
                        state_d = ST_DONE;
                    end else if (cfg_q.gap == '0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (!hold_i && gap_zero) begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    // Captured transfer settings and symbol index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            cfg_q <= '{pat: pat_i, len: clamp_len(len_i), gap: gap_i};
            idx_q <= '0;
        end else if ((state_q == ST_SEND) && !hold_i && !abort_i) begin
            idx_q <= last_sym ? '0 : idx_q + IDX_W'(1);
        end
    end

    // Link outputs; hold blanks the symbol in the same cycle
    always_comb begin
        num_o     = SYM_IDLE;
        num_vld_o = 1'b0;
        busy_o    = (state_q != ST_IDLE);
        done_o    = (state_q == ST_DONE);
        if ((state_q == ST_SEND) && !hold_i) begin
            num_o     = sym_at(cfg_q.pat, idx_q);
            num_vld_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_sym_seq_tx.sv
// Scoreboard bench for sym_seq_tx: expected per-cycle outputs queued at stimulus time.
module tb_sym_seq_tx;
    import sym_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             start_i;
    logic             abort_i;
    logic             hold_i;
    logic [PAT_W-1:0] pat_i;
    logic [LEN_W-1:0] len_i;
    logic [REP_W-1:0] reps_i;
    logic [GAP_W-1:0] gap_i;
    logic [SYM_W-1:0] num_o;
    logic             num_vld_o;
    logic             busy_o;
    logic             done_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Entry layout: {busy, done, vld, num[1:0]}
    logic [4:0] sb_q[$];

    sym_seq_tx dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .abort_i   (abort_i),
        .hold_i    (hold_i),
        .pat_i     (pat_i),
        .len_i     (len_i),
        .reps_i    (reps_i),
        .gap_i     (gap_i),
        .num_o     (num_o),
        .num_vld_o (num_vld_o),
        .busy_o    (busy_o),
        .done_o    (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [4:0] ent(input logic b, input logic d, input logic v,
                                       input logic [1:0] n);
        return {b, d, v, n};
    endfunction

    // Reference model for an uninterrupted transfer, starting with the cycle that carries start
    task automatic push_model(input logic [PAT_W-1:0] p, input int len, input int reps,
                              input int gap);
        int l;
        l = (len > 8) ? 8 : len;
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        if (l != 0) begin
            for (int r = 0; r <= reps; r++) begin
                for (int i = 0; i < l; i++) sb_q.push_back(ent(1, 0, 1, p[2*i +: 2]));
                if (r != reps) for (int g = 0; g < gap; g++) sb_q.push_back(ent(1, 0, 0, 2'b00));
            end
        end
        sb_q.push_back(ent(1, 1, 0, 2'b00));
        sb_q.push_back(ent(0, 0, 0, 2'b00));
    endtask

    // Compare one expected entry per cycle, away from the active edge
    always @(negedge clk) begin
        if (sb_q.size() != 0) begin
            logic [4:0] e;
            e = sb_q.pop_front();
            check_eq("num",  32'(num_o),     32'(e[1:0]));
            check_eq("vld",  32'(num_vld_o), 32'(e[2]));
            check_eq("done", 32'(done_o),    32'(e[3]));
            check_eq("busy", 32'(busy_o),    32'(e[4]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // After start has been driven this cycle: drop start, scramble inputs, run until drained
    task automatic run_out();
        tick();
        start_i = 1'b0;
        pat_i   = PAT_W'($urandom);
        len_i   = LEN_W'($urandom);
        reps_i  = REP_W'($urandom);
        gap_i   = GAP_W'($urandom);
        for (int k = 0; k < 300 && sb_q.size() != 0; k++) tick();
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic go(input logic [PAT_W-1:0] p, input int len, input int reps, input int gap);
        pat_i   = p;
        len_i   = LEN_W'(len);
        reps_i  = REP_W'(reps);
        gap_i   = GAP_W'(gap);
        start_i = 1'b1;
        push_model(p, len, reps, gap);
    endtask

    initial begin
        rst_n   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        hold_i  = 1'b0;
        pat_i   = '0;
        len_i   = '0;
        reps_i  = '0;
        gap_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_num",  32'(num_o),     32'd0);
        check_eq("rst_vld",  32'(num_vld_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o),    32'd0);
        check_eq("rst_done", 32'(done_o),    32'd0);
        rst_n = 1'b1;
        tick();

        // Basic three-symbol pass
        go(PAT_W'(6'b11_10_01), 3, 0, 0);
        run_out();

        // Two passes separated by a two-cycle gap
        go(PAT_W'(4'b10_01), 2, 1, 2);
        run_out();

        // Hold during SEND: symbol 1 blanked then resent
        pat_i = PAT_W'(6'b11_10_01); len_i = 4'd3; reps_i = '0; gap_i = '0; start_i = 1'b1;
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b01));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b10));
        sb_q.push_back(ent(1, 0, 1, 2'b11));
        sb_q.push_back(ent(1, 1, 0, 2'b00));
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        tick(); start_i = 1'b0;
        tick(); hold_i = 1'b1;
        tick();
        tick(); hold_i = 1'b0;
        run_out();

        // Hold during GAP stretches the gap by one cycle
        pat_i = PAT_W'(4'b10_01); len_i = 4'd2; reps_i = 4'd1; gap_i = 4'd2; start_i = 1'b1;
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b01));
        sb_q.push_back(ent(1, 0, 1, 2'b10));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b01));
        sb_q.push_back(ent(1, 0, 1, 2'b10));
        sb_q.push_back(ent(1, 1, 0, 2'b00));
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        tick(); start_i = 1'b0;
        tick();
        tick();
        tick(); hold_i = 1'b1;
        tick(); hold_i = 1'b0;
        run_out();

        // Abort in GAP, then an immediate restart beats nothing and is accepted
        pat_i = PAT_W'(4'b10_01); len_i = 4'd2; reps_i = 4'd1; gap_i = 4'd2; start_i = 1'b1;
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b01));
        sb_q.push_back(ent(1, 0, 1, 2'b10));
        sb_q.push_back(ent(1, 0, 0, 2'b00));
        tick(); start_i = 1'b0;
        tick();
        tick(); abort_i = 1'b1; start_i = 1'b1;
        tick(); abort_i = 1'b0;
        go(PAT_W'(6'b11_10_01), 3, 0, 0);
        run_out();

        // Zero length and over-long length
        go(PAT_W'(16'hFFFF), 0, 3, 3);
        run_out();
        go(PAT_W'(16'b00_11_10_01_11_01_10_11), 12, 0, 0);
        run_out();

        // Start while busy is ignored
        go(PAT_W'(6'b01_11_10), 3, 1, 1);
        tick(); start_i = 1'b0;
        tick(); start_i = 1'b1; pat_i = PAT_W'(16'hAAAA); len_i = 4'd5;
        run_out();

        // Async reset in the middle of SEND
        go(PAT_W'(6'b11_10_01), 3, 0, 0);
        sb_q.delete();
        sb_q.push_back(ent(0, 0, 0, 2'b00));
        sb_q.push_back(ent(1, 0, 1, 2'b01));
        tick(); start_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("midrst_num",  32'(num_o),     32'd0);
        check_eq("midrst_vld",  32'(num_vld_o), 32'd0);
        check_eq("midrst_busy", 32'(busy_o),    32'd0);
        check_eq("midrst_done", 32'(done_o),    32'd0);
        tick();
        tick(); rst_n = 1'b1;
        repeat (4) sb_q.push_back(ent(0, 0, 0, 2'b00));
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) tick();
        go(PAT_W'(6'b11_10_01), 3, 0, 0);
        run_out();

        // Random uninterrupted transfers
        for (int t = 0; t < 8; t++) begin
            go(PAT_W'($urandom), int'($urandom_range(0, 12)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
            run_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
